// File: rtl/msx_mouse_poller.sv
// MSX mouse strobe/nibble poller: toggles pin 8, samples four nibbles and the buttons, presents signed X/Y deltas.
// Define MOUSE_ACCUM_EN to accumulate saturating deltas between consumer acks instead of overwriting them.
module msx_mouse_poller #(
  parameter int SETTLE_CYCLES = 200,
  parameter int POLL_PERIOD   = 358000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  output logic       strobe,
  input  logic [5:0] pdata,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       busy,
  input  logic       ack
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(POLL_PERIOD + 1);

  typedef enum logic [2:0] {IDLE, TOGGLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          trig;
  logic [1:0]    idx;
  logic [3:0]    nib0, nib1, nib2;
  logic [7:0]    new_dx, new_dy;

  assign new_dx = {nib0, nib1};
  assign new_dy = {nib2, pdata[3:0]};

`ifdef MOUSE_ACCUM_EN
  logic [7:0] last_dx, last_dy;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)
      return 8'h7F;
    else if (s < -9'sd128)
      return 8'h80;
    else
      return s[7:0];
  endfunction
`else
  logic unused_ack;
  assign unused_ack = ack;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      timer  <= '0;
      trig   <= 1'b0;
      idx    <= 2'd0;
      nib0   <= 4'd0;
      nib1   <= 4'd0;
      nib2   <= 4'd0;
      strobe <= 1'b0;
      dx     <= 8'd0;
      dy     <= 8'd0;
      btn    <= 2'b00;
      valid  <= 1'b0;
      busy   <= 1'b0;
`ifdef MOUSE_ACCUM_EN
      last_dx <= 8'd0;
      last_dy <= 8'd0;
`endif
    end else begin
      valid <= 1'b0;
      trig  <= 1'b0;

      // The timer pauses during the trigger cycle so the period is POLL_PERIOD idle cycles plus the poll itself.
      if (!enable) begin
        timer <= '0;
      end else if (state == IDLE && !trig) begin
        if (timer == TW'(POLL_PERIOD - 1)) begin
          timer <= '0;
          trig  <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end

`ifdef MOUSE_ACCUM_EN
      if (ack && state != DONE) begin
        dx <= 8'd0;
        dy <= 8'd0;
      end
`endif

      case (state)
        IDLE: begin
          if (poll_req || trig) begin
            strobe <= ~strobe;
            busy   <= 1'b1;
            idx    <= 2'd0;
            cnt    <= '0;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 2))
            state <= SAMPLE;
          else
            cnt <= cnt + 1'b1;
        end
        SAMPLE: begin
          case (idx)
            2'd0:    nib0 <= pdata[3:0];
            2'd1:    nib1 <= pdata[3:0];
            2'd2:    nib2 <= pdata[3:0];
            default: ;
          endcase
          if (idx == 2'd3) begin
            btn   <= ~pdata[5:4];
            valid <= 1'b1;
            state <= DONE;
`ifdef MOUSE_ACCUM_EN
            last_dx <= new_dx;
            last_dy <= new_dy;
            dx <= sat_add(ack ? 8'd0 : dx, new_dx);
            dy <= sat_add(ack ? 8'd0 : dy, new_dy);
`else
            dx <= new_dx;
            dy <= new_dy;
`endif
          end else begin
            idx   <= idx + 2'd1;
            state <= TOGGLE;
          end
        end
        TOGGLE: begin
          strobe <= ~strobe;
          cnt    <= '0;
          state  <= SETTLE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef MOUSE_ACCUM_EN
          // An ack here covers the sum presented with valid; keep only the delta just sampled.
          if (ack) begin
            dx <= last_dx;
            dy <= last_dy;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
